// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner with iterative shift-add multiply and restoring divide for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Define MD_SINGLE_CYCLE_MUL_EN for a combinational multiply (1-cycle busy); divide stays iterative.
module hilo_muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      func_code,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   p_q, p_d;      // {acc/rem, multiplier/quotient}
    logic [XLEN-1:0]     d_q, d_d;      // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [XLEN-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                done_q, done_d, divz_q, divz_d;

    logic                is_mul_op, is_div_op, is_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [XLEN:0]       mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0]   mul_raw, mul_res;
    logic [XLEN-1:0]     quo_res, rem_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            d_q      <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            d_q      <= d_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            divz_q   <= divz_d;
        end
    end

    always_comb begin
        is_mul_op = (func_code == F_MULT) || (func_code == F_MULTU);
        is_div_op = (func_code == F_DIV)  || (func_code == F_DIVU);
        is_sgn    = (func_code == F_MULT) || (func_code == F_DIV);
        a_neg     = is_sgn & op1[XLEN-1];
        b_neg     = is_sgn & op2[XLEN-1];
        a_abs     = a_neg ? -op1 : op1;
        b_abs     = b_neg ? -op2 : op2;

        mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, (p_q[0] ? d_q : '0)};
        div_sh   = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_diff = div_sh - {1'b0, d_q};

`ifdef MD_SINGLE_CYCLE_MUL_EN
        mul_raw = {{XLEN{1'b0}}, d_q} * {{XLEN{1'b0}}, p_q[XLEN-1:0]};
`else
        mul_raw = p_q;
`endif
        mul_res = qneg_q ? -mul_raw : mul_raw;
        // Divide-by-zero needs no special remainder: all-subtract-zero leaves |op1|, re-signed below.
        quo_res = dz_q ? '1 : (qneg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0]);
        rem_res = rneg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        d_d      = d_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        divz_d   = divz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    if (func_code == F_MTHI) begin
                        hi_d   = op1;
                        divz_d = 1'b0;
                    end else if (func_code == F_MTLO) begin
                        lo_d   = op1;
                        divz_d = 1'b0;
                    end else if (is_mul_op || is_div_op) begin
                        divz_d   = 1'b0;
                        cnt_d    = '0;
                        is_div_d = is_div_op;
                        qneg_d   = a_neg ^ b_neg;
                        rneg_d   = a_neg;
                        dz_d     = is_div_op && (op2 == '0);
                        if (is_div_op) begin
                            p_d     = {{XLEN{1'b0}}, a_abs};
                            d_d     = b_abs;
                            state_d = S_DIV;
                        end else begin
                            p_d     = {{XLEN{1'b0}}, b_abs};
                            d_d     = a_abs;
`ifdef MD_SINGLE_CYCLE_MUL_EN
                            state_d = S_FIX;
`else
                            state_d = S_MUL;
`endif
                        end
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (state_q == S_MUL) begin
                        p_d = {mul_sum, p_q[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        p_d = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
                    end else begin
                        p_d = {div_sh[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    divz_d = is_div_q & dz_q;
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = mul_res[2*XLEN-1:XLEN];
                        lo_d = mul_res[XLEN-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = done_q;
        div_zero = divz_q;
        hi       = hi_q;
        lo       = lo_q;
    end
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized and directed check of hilo_muldiv_ctrl against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef MD_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [5:0]  func_code;
    logic [31:0] op1, op2;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    hilo_muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .func_code(func_code),
        .op1(op1), .op2(op2), .flush(flush), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic, truncating division, remainder follows dividend.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        logic [63:0] p, q, r;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        p = '0; q = '0; r = '0;
        case (f)
            F_MULT:  p = 64'(sa * sb);
            F_MULTU: p = {32'b0, a} * {32'b0, b};
            F_DIV:   if (b != 0) begin q = 64'(sa / sb); r = 64'(sa % sb); end
            F_DIVU:  if (b != 0) begin q = {32'b0, a / b}; r = {32'b0, a % b}; end
            default: ;
        endcase
        if ((f == F_DIV || f == F_DIVU) && b == 0) begin
            h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (f == F_DIV || f == F_DIVU) begin
            h = r[31:0]; l = q[31:0];
        end else begin
            h = p[63:32]; l = p[31:0];
        end
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        logic        edz;
        int          n;
        bit          seen;
        model(f, a, b, eh, el, edz);
        func_code = f; op1 = a; op2 = b; start = 1'b1;
        tick();
        start = 1'b0; op1 = $urandom; op2 = $urandom; func_code = 6'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("done_low_after_start", 64'(done), 64'(0));
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (done) seen = 1;
        end
        chk("latency", 64'(n), 64'((f == F_DIV || f == F_DIVU) ? DIV_LAT : MUL_LAT));
        chk("busy_at_done", 64'(busy), 64'(0));
        chk("hi", 64'(hi), 64'(eh));
        chk("lo", 64'(lo), 64'(el));
        chk("div_zero", 64'(div_zero), 64'(edz));
        hi_m = eh; lo_m = el;
    endtask

    task automatic mt_op(input logic [5:0] f, input logic [31:0] v, input logic fl);
        func_code = f; op1 = v; start = 1'b1; flush = fl;
        tick();
        start = 1'b0; flush = 1'b0;
        if (!fl) begin
            if (f == F_MTHI) hi_m = v;
            if (f == F_MTLO) lo_m = v;
        end
        chk("mt_busy", 64'(busy), 64'(0));
        chk("mt_done", 64'(done), 64'(0));
        chk("mt_hi", 64'(hi), 64'(hi_m));
        chk("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] fs [4];
        int dones;
        fs[0] = F_MULT; fs[1] = F_MULTU; fs[2] = F_DIV; fs[3] = F_DIVU;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; func_code = '0; op1 = '0; op2 = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        tick();

        // Directed corner cases; each op starts in the previous op's done cycle.
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
        run_op(F_DIVU, 32'd100, 32'd0);
        chk("divu_zero_hi", 64'(hi), 64'd100);
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        run_op(F_DIV, 32'h8000_0005, 32'd0);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000);

        mt_op(F_MTLO, 32'h0000_1234, 1'b0);
        mt_op(F_MTHI, $urandom, 1'b0);
        mt_op(F_MTHI, 32'hDEAD_BEEF, 1'b1);
        mt_op(6'b111111, 32'h5555_AAAA, 1'b0);

        // DIV with an MTLO attempt while busy, then flush at cycle 10.
        func_code = F_DIV; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 4) begin func_code = F_MTLO; op1 = 32'hCAFE_F00D; start = 1'b1; end
            tick();
            start = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dones++;
            tick();
        end
        chk("flush_no_done", 64'(dones), 64'(0));
        chk("flush_hi", 64'(hi), 64'(hi_m));
        chk("flush_lo", 64'(lo), 64'(lo_m));

        // Flush landing in the final correction cycle.
        func_code = F_DIVU; op1 = 32'd77; op2 = 32'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        chk("pre_fix_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fixflush_done", 64'(done), 64'(0));
        chk("fixflush_busy", 64'(busy), 64'(0));
        chk("fixflush_hi", 64'(hi), 64'(hi_m));
        chk("fixflush_lo", 64'(lo), 64'(lo_m));

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_op(fs[$urandom_range(0, 3)], a, b);
        end

        // Asynchronous reset in the middle of a multiply.
        func_code = F_MULT; op1 = 32'd12345; op2 = 32'hFFFF_0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("amid_busy", 64'(busy), 64'(0));
        chk("amid_done", 64'(done), 64'(0));
        chk("amid_dz", 64'(div_zero), 64'(0));
        chk("amid_hi", 64'(hi), 64'(0));
        chk("amid_lo", 64'(lo), 64'(0));
        hi_m = '0; lo_m = '0;
        #4 rst_n = 1'b1;
        tick();
        run_op(F_MULT, 32'd6, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
